bcd_inc_scheduler: RTL and testbench
====================================

Name: bcd_inc_scheduler

Overview:
Round-robin scheduler that shares one N-digit BCD incrementer between NUM_REQ event channels. Each channel owns a BCD count register. Incoming one-cycle event strobes are latched as pending requests. The block serves one pending channel at a time: read count, increment in BCD, write back. It sits between the debounced button/event logic and the 12864 display formatter, which reads counts through a combinational read port.

Parameters:
NUM_REQ, 4, number of event channels (2..8)
DIGITS, 3, BCD digits per count; count width is 4*DIGITS

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
evt  in  NUM_REQ  one-cycle event strobes, one bit per channel
clr_all  in  1  synchronous clear of all counts and pending state
rd_sel  in  clog2(NUM_REQ)  channel selected for readout
rd_bcd  out  4*DIGITS  count of channel rd_sel (combinational from registers)
done  out  NUM_REQ  one-cycle pulse, bit i set when channel i write-back occurs
wrap  out  NUM_REQ  one-cycle pulse with done when count rolled all-nines to zero
miss  out  NUM_REQ  sticky; set when an event is lost
busy  out  1  high when any pending bit is set or FSM is not in IDLE

Behaviour:
- Reset (rst=1, synchronous):
  - all counts = 0; pending = 0; miss = 0; done = 0; wrap = 0.
  - FSM = IDLE; round-robin pointer = 0.
  - rst has priority over every other input.
- Pending latch:
  - evt[i]=1 sets pending[i] next cycle.
  - evt[i]=1 while pending[i] is already 1 and channel i is not being written back this cycle sets miss[i]; the event is dropped.
  - evt[i] in the same cycle as channel i write-back: set wins over clear, pending[i] stays 1, no miss.
- FSM (2 states):
  - IDLE: if any pending bit is set, pick the winner by round-robin, searching from ptr upward with wrap. Latch sel = winner, go to INC. Otherwise stay in IDLE.
  - INC: next_count = BCD increment of count[sel]. Write back, clear pending[sel], pulse done[sel] for 1 cycle, set ptr = sel+1 mod NUM_REQ, go to IDLE.
- Latency: evt at cycle t -> pending at t+1 -> IDLE grant at t+1 -> write-back and done at t+2, if uncontended.
- Throughput: one increment per 2 cycles. Worst-case wait is 2*NUM_REQ cycles.
- Arithmetic:
  - Each digit 0..9; a digit of 9 becomes 0 with carry into the next digit.
  - All-nines wraps to all-zeros and asserts wrap[sel] together with done[sel].
  - Input digits >9 are illegal and behaviour is unspecified; bench keeps them legal.
- clr_all=1:
  - next cycle: counts, pending, miss = 0; FSM = IDLE; ptr unchanged.
  - A write-back scheduled in the same cycle is discarded; done/wrap are not pulsed.
  - evt in the same cycle as clr_all is dropped.
- rd_bcd reflects the register value. A write-back becomes visible on the cycle after done.

Optional Feature:
BCD_SAT_EN
- Defined: counts saturate at all-nines.
  - An increment at all-nines leaves the value unchanged and still pulses done.
  - wrap is replaced by the same pulse meaning "saturated event"; the port is kept.
- Undefined: wrap-around as described above.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4, BCD_NINE=4'h9, BCD_ZERO=4'h0.
  - FSM state typedef {IDLE, INC}.
  - Function for clog2-based select width.
- Sub-module bcd_incrementer_n:
  - Parameter DIGITS; combinational.
  - Inputs: bcd_in, sat (tied per macro).
  - Outputs: bcd_out, all_nines.
  - One instance is shared by all channels through the sel mux.

Test Plan:
- Reset, then single evt[0] at cycle 5 -> done[0] at cycle 7, rd_sel=0 reads 12'h001, busy low by cycle 8.
- Preload channel 1 to 12'h099 via 99 events, then 1 more -> 12'h100, no wrap; at 12'h999 one more -> 12'h000 with wrap[1]=done[1]=1 (BCD_SAT_EN: stays 12'h999).
- evt=4'b1111 in one cycle -> done order ch0, ch1, ch2, ch3 at cycles +2, +4, +6, +8; next simultaneous burst after ptr=0 again starts at ch0; with ptr=2 it starts at ch2.
- evt[2] on two consecutive cycles while ch2 is not yet served -> miss[2]=1 sticky, count advances by 1 only; evt[2] coincident with ch2 write-back -> no miss, count advances by 2.
- clr_all asserted in an INC cycle for ch3 at count 12'h005 -> no done, all counts 0, miss cleared, FSM IDLE.
- rst mid-burst with pending=4'b0110 -> all outputs zero next cycle, no further done pulses.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD event-count scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: BCD digit constants, the two-state scheduler FSM type, and a
// select-width helper that keeps a 1-bit select for two-channel builds.
package bcd_pkg;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_NINE = 4'h9;
    localparam logic [3:0] BCD_ZERO = 4'h0;

    typedef enum logic {
        IDLE = 1'b0,
        INC  = 1'b1
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_incrementer_n.sv
// N-digit BCD incrementer, optionally saturating at all-nines.
// Latency: combinational.
// Backpressure: none; the output always follows the input.
// Ports:
//   bcd_in    - DIGITS packed BCD digits, least significant digit in [3:0]
//   sat       - 1: all-nines stays all-nines; 0: all-nines wraps to zero
//   bcd_out   - incremented value
//   all_nines - bcd_in is the largest representable value
module bcd_incrementer_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    input  logic                      sat,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      all_nines
);

    logic       carry;
    logic       nines;
    logic [3:0] dig;

    // Ripple the +1 from the least significant digit: a 9 rolls to 0 and
    // passes the carry on, any other digit absorbs it.
    always_comb begin
        carry   = 1'b1;
        nines   = 1'b1;
        dig     = BCD_ZERO;
        bcd_out = bcd_in;
        for (int d = 0; d < DIGITS; d++) begin
            dig   = bcd_in[d*DIGIT_W +: DIGIT_W];
            nines = nines & (dig == BCD_NINE);
            if (carry) begin
                if (dig == BCD_NINE) begin
                    bcd_out[d*DIGIT_W +: DIGIT_W] = BCD_ZERO;
                end else begin
                    bcd_out[d*DIGIT_W +: DIGIT_W] = dig + 4'd1;
                    carry                         = 1'b0;
                end
            end
        end
        if (sat && nines) begin
            bcd_out = bcd_in;
        end
    end

    assign all_nines = nines;

endmodule

// File: rtl/bcd_inc_scheduler.sv
// Round-robin scheduler sharing one BCD incrementer across NUM_REQ channels.
// Latency: evt at t -> grant at t+1 -> done/write-back at t+2; value readable at t+3.
// Backpressure: none; one pending slot per channel, a repeat event while pending is dropped and flagged in miss.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (highest priority)
//   evt           - one-cycle event strobes, one per channel
//   clr_all       - synchronous clear of counts, pending and miss (ptr kept)
//   rd_sel/rd_bcd - combinational readout of one channel's count
//   done/wrap     - write-back pulse per channel; wrap marks an all-nines increment
//   miss          - sticky per-channel lost-event flag
//   busy          - pending work or an increment in flight
// Build option: define BCD_SAT_EN to make counts saturate at all-nines;
// wrap then marks the saturated increment instead of a roll-over.
module bcd_inc_scheduler
    import bcd_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DIGITS  = 3,
    localparam int SEL_W   = sel_w(NUM_REQ),
    localparam int CW      = DIGIT_W * DIGITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] evt,
    input  logic               clr_all,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CW-1:0]      rd_bcd,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] wrap,
    output logic [NUM_REQ-1:0] miss,
    output logic               busy
);

`ifdef BCD_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q [NUM_REQ];
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [NUM_REQ-1:0] miss_q, miss_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic               wb_vld;
    logic [NUM_REQ-1:0] sel_oh;
    logic [NUM_REQ-1:0] wb_oh;
    logic [SEL_W-1:0]   grant_idx;
    logic               grant_fnd;
    logic [CW-1:0]      inc_in;
    logic [CW-1:0]      inc_out;
    logic               inc_nines;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pend_q) state_d = INC;
            INC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. A write-back coinciding with clr_all or rst is discarded,
    // so the done/wrap pulses are suppressed in that cycle as well.
    always_comb begin
        wb_vld = (state_q == INC) && !clr_all && !rst;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_oh[i] = (sel_q == SEL_W'(i));
        end
        wb_oh = wb_vld ? sel_oh : '0;
        done  = wb_oh;
        wrap  = inc_nines ? wb_oh : '0;
        busy  = (|pend_q) || (state_q != IDLE);
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first pending channel at or above ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        grant_idx = '0;
        grant_fnd = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_fnd && pend_q[(int'(ptr_q) + k) % NUM_REQ]) begin
                grant_fnd = 1'b1;
                grant_idx = SEL_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        ptr_d = ptr_q;
        if (state_q == IDLE && grant_fnd) begin
            sel_d = grant_idx;
        end
        if (wb_vld) begin
            ptr_d = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : SEL_W'(sel_q + 1'b1);
        end
    end

    // A new event beats the write-back clear, so an event landing on its own
    // channel's write-back cycle is queued rather than counted as a miss.
    always_comb begin
        pend_d = (pend_q & ~wb_oh) | evt;
        miss_d = miss_q | (evt & pend_q & ~wb_oh);
    end

    // ------------------------------------------------------------------
    // Shared incrementer
    // ------------------------------------------------------------------
    assign inc_in = count_q[sel_q];

    bcd_incrementer_n #(
        .DIGITS (DIGITS)
    ) u_inc (
        .bcd_in    (inc_in),
        .sat       (SAT),
        .bcd_out   (inc_out),
        .all_nines (inc_nines)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) count_q[i] <= '0;
            pend_q <= '0;
            miss_q <= '0;
            sel_q  <= '0;
            ptr_q  <= '0;
        end else if (clr_all) begin
            // ptr deliberately survives a clear so fairness carries over.
            for (int i = 0; i < NUM_REQ; i++) count_q[i] <= '0;
            pend_q <= '0;
            miss_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (wb_oh[i]) count_q[i] <= inc_out;
            end
            pend_q <= pend_d;
            miss_q <= miss_d;
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
        end
    end

    assign rd_bcd = count_q[rd_sel];
    assign miss   = miss_q;

endmodule

// File: tb/tb_bcd_inc_scheduler.sv
// Self-checking bench for bcd_inc_scheduler (NUM_REQ=4, DIGITS=3).
// Directed scenarios followed by random events, all compared every cycle
// against a transaction-level model using integer counts.
module tb_bcd_inc_scheduler;

    localparam int N    = 4;
    localparam int D    = 3;
    localparam int CW   = 4 * D;
    localparam int SW   = 2;
    localparam int MAXV = 999;
`ifdef BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  evt = '0;
    logic          clr_all = 1'b0;
    logic [SW-1:0] rd_sel = '0;
    logic [CW-1:0] rd_bcd;
    logic [N-1:0]  done, wrap, miss;
    logic          busy;

    bcd_inc_scheduler #(.NUM_REQ(N), .DIGITS(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .evt     (evt),
        .clr_all (clr_all),
        .rd_sel  (rd_sel),
        .rd_bcd  (rd_bcd),
        .done    (done),
        .wrap    (wrap),
        .miss    (miss),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: integer counts, pending set, the channel in service.
    int       m_cnt [N];
    bit [N-1:0] m_pend;
    bit [N-1:0] m_miss;
    int       m_serv;
    int       m_ptr;
    bit       m_valid = 1'b0;

    // Last observed DUT outputs and a log of write-backs.
    logic [N-1:0]  o_done, o_wrap, o_miss;
    logic          o_busy;
    logic [CW-1:0] o_rd;
    int            done_ch[$];
    int            done_at[$];
    bit            wrap_seen;

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int d = 0; d < D; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare all outputs mid-cycle, advance model.
    task automatic step(input logic [N-1:0] e, input logic c, input logic r, input logic [SW-1:0] rs);
        logic [N-1:0]  e_done, e_wrap;
        logic          e_busy;
        int            nserv;
        evt = e; clr_all = c; rst = r; rd_sel = rs;
        @(negedge clk);
        o_done = done; o_wrap = wrap; o_miss = miss; o_busy = busy; o_rd = rd_bcd;
        for (int i = 0; i < N; i++) begin
            if (o_done[i] === 1'b1) begin
                done_ch.push_back(i);
                done_at.push_back(cyc);
            end
        end
        if (o_wrap !== '0) wrap_seen = 1'b1;
        if (m_valid) begin
            e_done = (m_serv >= 0 && !c && !r) ? N'(1 << m_serv) : '0;
            e_wrap = (e_done != '0 && m_cnt[m_serv] == MAXV) ? e_done : '0;
            e_busy = (m_pend != '0) || (m_serv >= 0);
            chk("done",   32'(o_done), 32'(e_done));
            chk("wrap",   32'(o_wrap), 32'(e_wrap));
            chk("miss",   32'(o_miss), 32'(m_miss));
            chk("busy",   32'(o_busy), 32'(e_busy));
            chk("rd_bcd", 32'(o_rd),   32'(to_bcd(m_cnt[rs])));
        end else begin
            e_done = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_pend = '0; m_miss = '0; m_serv = -1; m_ptr = 0; m_valid = 1'b1;
        end else if (c) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_pend = '0; m_miss = '0; m_serv = -1;
        end else begin
            nserv = -1;
            if (m_serv >= 0) begin
                if (m_cnt[m_serv] == MAXV) m_cnt[m_serv] = SAT ? MAXV : 0;
                else                       m_cnt[m_serv] = m_cnt[m_serv] + 1;
                m_ptr = (m_serv + 1) % N;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (nserv < 0 && m_pend[(m_ptr + k) % N]) nserv = (m_ptr + k) % N;
                end
            end
            m_miss = m_miss | (e & m_pend & ~e_done);
            m_pend = (m_pend & ~e_done) | e;
            m_serv = nserv;
        end
    endtask

    task automatic idle(input int n, input logic [SW-1:0] rs);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, rs);
    endtask

    // Uncontended event: last step observes the written-back value.
    task automatic pulse(input int ch);
        step(N'(1 << ch), 1'b0, 1'b0, SW'(ch));
        idle(3, SW'(ch));
    endtask

    task automatic burst(input int first, input string tag);
        int t0;
        t0 = cyc;
        done_ch.delete(); done_at.delete();
        step('1, 1'b0, 1'b0, '0);
        idle(8, '0);
        chk({tag, "_ndone"}, 32'(done_ch.size()), 32'd4);
        for (int k = 0; k < 4 && k < done_ch.size(); k++) begin
            chk({tag, "_order"}, 32'(done_ch[k]), 32'((first + k) % N));
            chk({tag, "_time"},  32'(done_at[k]), 32'(t0 + 2 + 2 * k));
        end
    endtask

    initial begin
        logic [N-1:0] re;
        m_serv = -1; m_ptr = 0; m_pend = '0; m_miss = '0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        wrap_seen = 1'b0;

        // Reset, single event on ch0 at cycle 5.
        step('0, 1'b0, 1'b1, '0);
        step('0, 1'b0, 1'b1, '0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        idle(3, '0);
        done_ch.delete(); done_at.delete();
        step(4'b0001, 1'b0, 1'b0, '0);
        idle(3, '0);
        chk("t1_ndone", 32'(done_ch.size()), 32'd1);
        if (done_at.size() > 0) chk("t1_done_cyc", 32'(done_at[0]), 32'd7);
        chk("t1_rd", 32'(o_rd), 32'h001);
        chk("t1_busy", 32'(o_busy), 32'd0);

        // Round-robin order: move ptr to 0, two bursts, then ptr to 2.
        pulse(3);
        burst(0, "burstA");
        burst(0, "burstB");
        pulse(1);
        burst(2, "burstC");

        // Counting and roll-over on ch1.
        step('0, 1'b1, 1'b0, '0);
        wrap_seen = 1'b0;
        for (int i = 0; i < 99; i++) pulse(1);
        chk("ch1_099", 32'(o_rd), 32'h099);
        pulse(1);
        chk("ch1_100", 32'(o_rd), 32'h100);
        chk("ch1_nowrap", 32'(wrap_seen), 32'd0);
        for (int i = 0; i < 899; i++) pulse(1);
        chk("ch1_999", 32'(o_rd), 32'h999);
        wrap_seen = 1'b0;
        pulse(1);
        chk("ch1_wrap", 32'(wrap_seen), 32'd1);
        chk("ch1_after", 32'(o_rd), SAT ? 32'h999 : 32'h000);

        // Lost event while pending.
        step('0, 1'b1, 1'b0, '0);
        step(4'b0100, 1'b0, 1'b0, 2'd2);
        step(4'b0100, 1'b0, 1'b0, 2'd2);
        idle(3, 2'd2);
        chk("miss_set", 32'(o_miss), 32'b0100);
        chk("miss_cnt", 32'(o_rd), 32'h001);
        idle(2, 2'd2);
        chk("miss_sticky", 32'(o_miss), 32'b0100);

        // Event coincident with its own write-back is kept.
        step('0, 1'b1, 1'b0, '0);
        step(4'b0100, 1'b0, 1'b0, 2'd2);
        step('0, 1'b0, 1'b0, 2'd2);
        step(4'b0100, 1'b0, 1'b0, 2'd2);
        idle(3, 2'd2);
        chk("coin_miss", 32'(o_miss), 32'd0);
        chk("coin_cnt", 32'(o_rd), 32'h002);

        // clr_all during ch3's increment.
        for (int i = 0; i < 5; i++) pulse(3);
        chk("ch3_005", 32'(o_rd), 32'h005);
        step(4'b1000, 1'b0, 1'b0, 2'd3);
        step(4'b1000, 1'b0, 1'b0, 2'd3);
        step('0, 1'b1, 1'b0, 2'd3);
        chk("clr_nodone", 32'(o_done), 32'd0);
        step('0, 1'b0, 1'b0, 2'd3);
        chk("clr_cnt3", 32'(o_rd), 32'h000);
        chk("clr_miss", 32'(o_miss), 32'd0);
        chk("clr_busy", 32'(o_busy), 32'd0);
        step('0, 1'b0, 1'b0, 2'd2);
        chk("clr_cnt2", 32'(o_rd), 32'h000);

        // Reset with two channels pending.
        step(4'b0110, 1'b0, 1'b0, '0);
        step('0, 1'b0, 1'b1, '0);
        done_ch.delete();
        idle(4, 2'd1);
        chk("rst_mid_ndone", 32'(done_ch.size()), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_rd", 32'(o_rd), 32'h000);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            re = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            step(re, ($urandom_range(0, 99) == 0), ($urandom_range(0, 299) == 0),
                 SW'($urandom_range(0, N - 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
